// File: rtl/arb_pkg.sv
// Shared definitions for the eight-way round-robin arbiter: requester count,
// index width, FSM state encoding and the one-hot to binary (octal) encoder.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  // Encode a one-hot (or zero) 8-bit vector into its 3-bit index; zero maps to 0.
  function automatic logic [IDX_W-1:0] onehot8_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/oct_rr_arbiter_pick.sv
// rr_pick8: combinational rotating-priority picker. Scans req (minus the
// masked owner) starting at ptr and wrapping, returning the first hit.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any
);

  logic [NUM_REQ-1:0] eligible_s;
  logic [IDX_W-1:0]   idx_s;
  logic               found_s;

  // Walk the priority order ptr, ptr+1, ... (mod 8) and keep the first eligible requester.
  always_comb begin
    eligible_s = req & ~mask;
    idx_s      = 3'd0;
    found_s    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [IDX_W-1:0] cand;
      cand = ptr + 3'(k);
      if (!found_s && eligible_s[cand]) begin
        found_s = 1'b1;
        idx_s   = cand;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Present the winner both as one-hot and as an index; all zero when nobody is eligible.
  always_comb begin
    if (found_s) begin
      win_oh  = 8'h01 << idx_s;
      win_idx = idx_s;
      any     = 1'b1;
    end else begin
      win_oh  = 8'h00;
      win_idx = 3'd0;
      any     = 1'b0;
    end
  end

endmodule

// File: rtl/oct_rr_arbiter.sv
// oct_rr_arbiter: eight-requester round-robin arbiter with registered one-hot
// grant, binary index and valid. The owner keeps the grant until it drops its
// request, then ownership passes with no bubble to the next requester.
// Optional feature macro: ARB_HOLD_LIMIT_EN -- bounds a single ownership to
// HOLD_MAX cycles while other requesters are waiting.
module oct_rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("oct_rr_arbiter: HOLD_MAX must be within 1..255");
  end

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               grant_valid_q, grant_valid_d;

  logic [NUM_REQ-1:0] pick_oh_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_any_s;
  logic               owner_req_s;
  logic               preempt_s;
  logic               new_grant_s;

  // The current owner is masked out so a handover always goes to someone else;
  // while idle grant_q is zero and every requester competes.
  rr_pick8 u_pick (
    .req     (req),
    .mask    (grant_q),
    .ptr     (ptr_q),
    .win_oh  (pick_oh_s),
    .win_idx (pick_idx_s),
    .any     (pick_any_s)
  );

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

  logic [7:0] hold_cnt_q, hold_cnt_d;

  // Force a handover once the owner has used its budget and someone else is waiting.
  always_comb begin
    if (state_q == OWNED && hold_cnt_q == (HOLD_MAX_C - 8'd1) && pick_any_s) begin
      preempt_s = 1'b1;
    end else begin
      preempt_s = 1'b0;
    end
  end

  // Count owned cycles, restart on each new grant or when idle, saturate at HOLD_MAX.
  always_comb begin
    if (new_grant_s || state_d != OWNED) begin
      hold_cnt_d = 8'd0;
    end else if (hold_cnt_q >= HOLD_MAX_C) begin
      hold_cnt_d = hold_cnt_q;
    end else begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= 8'd0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  // Without the hold limit an owner is never preempted.
  always_comb begin
    preempt_s = 1'b0;
  end
`endif

  // Does the current owner still want the resource?
  always_comb begin
    owner_req_s = req[grant_idx_q];
  end

  // Next-state logic: arbitrate when idle, on owner release or on preemption.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    new_grant_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          new_grant_s = 1'b1;
        end else begin
          grant_d       = 8'h00;
          grant_idx_d   = 3'd0;
          grant_valid_d = 1'b0;
        end
      end
      OWNED: begin
        if (!owner_req_s || preempt_s) begin
          if (pick_any_s) begin
            new_grant_s = 1'b1;
          end else begin
            state_d       = IDLE;
            grant_d       = 8'h00;
            grant_idx_d   = 3'd0;
            grant_valid_d = 1'b0;
          end
        end else begin
          state_d = OWNED;
        end
      end
      default: begin
        state_d       = IDLE;
        grant_d       = 8'h00;
        grant_idx_d   = 3'd0;
        grant_valid_d = 1'b0;
      end
    endcase

    if (new_grant_s) begin
      state_d       = OWNED;
      grant_d       = pick_oh_s;
      grant_idx_d   = onehot8_to_idx(pick_oh_s);
      grant_valid_d = 1'b1;
      ptr_d         = pick_idx_s + 3'd1;
    end else begin
      ptr_d = ptr_d;
    end
  end

  // State, pointer and output registers; reset clears outputs and restores requester 0 priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= 3'd0;
      grant_q       <= 8'h00;
      grant_idx_q   <= 3'd0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;

endmodule
